// File: rtl/irq_ctrl.sv
// Memory-mapped interrupt controller: synchronizes NUM_IRQ request lines, latches them
// as pending (edge or level per line), and raises a registered hwint for enabled requests.
module irq_ctrl #(
    parameter int NUM_IRQ     = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_IRQ-1:0] irq,
    input  logic               cs,
    input  logic               rd,
    input  logic               wr,
    input  logic [1:0]         addr,
    input  logic [31:0]        wdata,
    output logic [31:0]        rdata,
    output logic               hwint
);

    localparam logic [1:0] ADDR_PENDING = 2'd0;
    localparam logic [1:0] ADDR_ENABLE  = 2'd1;
    localparam logic [1:0] ADDR_MODE    = 2'd2;
    localparam logic [1:0] ADDR_CLAIM   = 2'd3;

    logic [NUM_IRQ-1:0] sync_q [SYNC_STAGES];
    logic [NUM_IRQ-1:0] irq_s;
    logic [NUM_IRQ-1:0] irq_d;
    logic [NUM_IRQ-1:0] pending;
    logic [NUM_IRQ-1:0] enable;
    logic [NUM_IRQ-1:0] mode;

    logic [NUM_IRQ-1:0] active;
    logic [NUM_IRQ-1:0] claim_onehot;
    logic [NUM_IRQ-1:0] pend_set;
    logic [NUM_IRQ-1:0] pend_clr;
    logic [NUM_IRQ-1:0] wmask;
    logic               claim_valid;
    logic [4:0]         claim_idx;
    logic               bus_rd;
    logic               bus_wr;
    logic               unused_wdata;

    assign irq_s        = sync_q[SYNC_STAGES-1];
    assign active       = pending & enable;
    assign bus_rd       = cs & rd;
    assign bus_wr       = cs & wr;
    assign wmask        = wdata[NUM_IRQ-1:0];
    assign unused_wdata = ^wdata[31:NUM_IRQ];

    // Lowest index wins; scanning downward lets the last hit be the highest priority.
    always_comb begin
        claim_valid  = 1'b0;
        claim_idx    = '0;
        claim_onehot = '0;
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (active[i]) begin
                claim_valid     = 1'b1;
                claim_idx       = 5'(i);
                claim_onehot    = '0;
                claim_onehot[i] = 1'b1;
            end
        end
    end

    always_comb begin
        pend_set = (mode & irq_s & ~irq_d) | (~mode & irq_s);
        pend_clr = '0;
        if (bus_wr && addr == ADDR_PENDING)
            pend_clr = pend_clr | wmask;
        if (bus_rd && addr == ADDR_CLAIM && claim_valid)
            pend_clr = pend_clr | claim_onehot;
    end

    always_comb begin
        rdata = '0;
        if (bus_rd) begin
            case (addr)
                ADDR_PENDING: rdata[NUM_IRQ-1:0] = pending;
                ADDR_ENABLE:  rdata[NUM_IRQ-1:0] = enable;
                ADDR_MODE:    rdata[NUM_IRQ-1:0] = mode;
                default:      rdata = {claim_valid, 26'b0, claim_idx};
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int s = 0; s < SYNC_STAGES; s++)
                sync_q[s] <= '0;
            irq_d <= '0;
        end else begin
            sync_q[0] <= irq;
            for (int s = 1; s < SYNC_STAGES; s++)
                sync_q[s] <= sync_q[s-1];
            irq_d <= irq_s;
        end
    end

    // Set after clear so a simultaneous set wins.
    always_ff @(posedge clk) begin
        if (rst) begin
            pending <= '0;
            enable  <= '0;
            mode    <= '0;
            hwint   <= 1'b0;
        end else begin
            pending <= (pending & ~pend_clr) | pend_set;
            if (bus_wr && addr == ADDR_ENABLE)
                enable <= wmask;
            if (bus_wr && addr == ADDR_MODE)
                mode <= wmask;
            hwint <= |active;
        end
    end

endmodule

// File: tb/tb_irq_ctrl.sv
// Directed bench for irq_ctrl: each task drives one scenario and checks against
// hand-computed values.
module tb_irq_ctrl;

    logic        clk;
    logic        rst;
    logic [7:0]  irq;
    logic        cs;
    logic        rd;
    logic        wr;
    logic [1:0]  addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        hwint;

    int n_checks;
    int n_fail;

    irq_ctrl #(.NUM_IRQ(8), .SYNC_STAGES(2)) dut (
        .clk   (clk),
        .rst   (rst),
        .irq   (irq),
        .cs    (cs),
        .rd    (rd),
        .wr    (wr),
        .addr  (addr),
        .wdata (wdata),
        .rdata (rdata),
        .hwint (hwint)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) tick();
    endtask

    task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
        cs = 1'b1; wr = 1'b1; rd = 1'b0; addr = a; wdata = d;
        tick();
        cs = 1'b0; wr = 1'b0; wdata = '0; addr = '0;
    endtask

    task automatic bus_read(input logic [1:0] a, output logic [31:0] d);
        cs = 1'b1; rd = 1'b1; wr = 1'b0; addr = a;
        #1;
        d = rdata;
        tick();
        cs = 1'b0; rd = 1'b0; addr = '0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        logic [31:0] d;
        do_reset();
        n_checks++;
        if (hwint !== 1'b0) begin
            n_fail++; $display("FAIL reset_hwint got %0b want 0", hwint);
        end
        for (int r = 0; r < 4; r++) begin
            bus_read(2'(r), d);
            n_checks++;
            if (d !== 32'h0) begin
                n_fail++; $display("FAIL reset_reg%0d got %08h want 00000000", r, d);
            end
        end
    endtask

    task automatic test_bus_rules();
        logic [31:0] d;
        cs = 1'b1; wr = 1'b1; rd = 1'b0; addr = 2'd1; wdata = 32'hFFFF_FFFF;
        #1;
        n_checks++;
        if (rdata !== 32'h0) begin
            n_fail++; $display("FAIL rdata_on_write got %08h want 00000000", rdata);
        end
        tick();
        cs = 1'b0; wr = 1'b0;
        bus_read(2'd1, d);
        n_checks++;
        if (d !== 32'h0000_00FF) begin
            n_fail++; $display("FAIL enable_upper_bits got %08h want 000000ff", d);
        end
        cs = 1'b1; wr = 1'b1; rd = 1'b1; addr = 2'd2; wdata = 32'h0000_005A;
        #1;
        n_checks++;
        if (rdata !== 32'h0) begin
            n_fail++; $display("FAIL rd_wr_prewrite got %08h want 00000000", rdata);
        end
        tick();
        cs = 1'b0; wr = 1'b0; rd = 1'b0;
        bus_read(2'd2, d);
        n_checks++;
        if (d !== 32'h0000_005A) begin
            n_fail++; $display("FAIL rd_wr_postwrite got %08h want 0000005a", d);
        end
        bus_write(2'd3, 32'hFFFF_FFFF);
        bus_read(2'd0, d);
        n_checks++;
        if (d !== 32'h0) begin
            n_fail++; $display("FAIL claim_write_ignored pending got %08h want 00000000", d);
        end
        do_reset();
    endtask

    task automatic test_edge_latency();
        logic [31:0] d;
        logic [3:0]  exp_h;
        bus_write(2'd1, 32'h01);
        bus_write(2'd2, 32'h01);
        idle(2);
        irq[0] = 1'b1;
        exp_h = 4'b1000;
        for (int e = 0; e < 4; e++) begin
            tick();
            if (e == 2) irq[0] = 1'b0;
            n_checks++;
            if (hwint !== exp_h[e]) begin
                n_fail++; $display("FAIL edge_latency edge%0d hwint got %0b want %0b", e + 1, hwint, exp_h[e]);
            end
        end
        bus_read(2'd0, d);
        n_checks++;
        if (d !== 32'h01) begin
            n_fail++; $display("FAIL edge_pending got %08h want 00000001", d);
        end
    endtask

    task automatic test_w1c_edge_hold();
        logic [31:0] d;
        irq[0] = 1'b1;
        idle(6);
        bus_write(2'd0, 32'h01);
        bus_read(2'd0, d);
        n_checks++;
        if (d !== 32'h0) begin
            n_fail++; $display("FAIL w1c_clear got %08h want 00000000", d);
        end
        n_checks++;
        if (hwint !== 1'b0) begin
            n_fail++; $display("FAIL w1c_hwint_fall got %0b want 0", hwint);
        end
        idle(3);
        bus_read(2'd0, d);
        n_checks++;
        if (d !== 32'h0) begin
            n_fail++; $display("FAIL w1c_no_reset_edge got %08h want 00000000", d);
        end
        irq[0] = 1'b0;
        idle(5);
    endtask

    task automatic test_level_claim();
        logic [31:0] d;
        bus_write(2'd2, 32'h00);
        bus_write(2'd1, 32'h04);
        bus_write(2'd0, 32'hFF);
        irq[2] = 1'b1;
        idle(5);
        n_checks++;
        if (hwint !== 1'b1) begin
            n_fail++; $display("FAIL level_hwint got %0b want 1", hwint);
        end
        bus_read(2'd3, d);
        n_checks++;
        if (d !== 32'h8000_0002) begin
            n_fail++; $display("FAIL level_claim got %08h want 80000002", d);
        end
        for (int k = 0; k < 3; k++) begin
            n_checks++;
            if (hwint !== 1'b1) begin
                n_fail++; $display("FAIL level_hwint_hold cycle%0d got %0b want 1", k, hwint);
            end
            tick();
        end
        bus_read(2'd0, d);
        n_checks++;
        if (d !== 32'h04) begin
            n_fail++; $display("FAIL level_reset_pending got %08h want 00000004", d);
        end
        irq[2] = 1'b0;
        idle(5);
        bus_write(2'd0, 32'hFF);
        idle(2);
        n_checks++;
        if (hwint !== 1'b0) begin
            n_fail++; $display("FAIL level_hwint_clear got %0b want 0", hwint);
        end
    endtask

    task automatic test_priority();
        logic [31:0] d;
        bus_write(2'd2, 32'h0A);
        bus_write(2'd1, 32'h0A);
        irq[1] = 1'b1;
        irq[3] = 1'b1;
        idle(5);
        bus_read(2'd3, d);
        n_checks++;
        if (d !== 32'h8000_0001) begin
            n_fail++; $display("FAIL prio_claim1 got %08h want 80000001", d);
        end
        bus_read(2'd3, d);
        n_checks++;
        if (d !== 32'h8000_0003) begin
            n_fail++; $display("FAIL prio_claim2 got %08h want 80000003", d);
        end
        n_checks++;
        if (hwint !== 1'b1) begin
            n_fail++; $display("FAIL prio_hwint_lag got %0b want 1", hwint);
        end
        bus_read(2'd3, d);
        n_checks++;
        if (d !== 32'h0) begin
            n_fail++; $display("FAIL prio_claim3 got %08h want 00000000", d);
        end
        n_checks++;
        if (hwint !== 1'b0) begin
            n_fail++; $display("FAIL prio_hwint_fall got %0b want 0", hwint);
        end
        irq[1] = 1'b0;
        irq[3] = 1'b0;
        idle(5);
    endtask

    task automatic test_set_wins();
        logic [31:0] d;
        bus_write(2'd2, 32'h01);
        bus_write(2'd1, 32'h01);
        irq[0] = 1'b1;
        idle(4);
        irq[0] = 1'b0;
        idle(5);
        irq[0] = 1'b1;
        tick();
        tick();
        bus_write(2'd0, 32'h01);
        bus_read(2'd0, d);
        n_checks++;
        if (d !== 32'h01) begin
            n_fail++; $display("FAIL set_wins got %08h want 00000001", d);
        end
        idle(2);
        bus_write(2'd0, 32'h01);
        bus_read(2'd0, d);
        n_checks++;
        if (d !== 32'h0) begin
            n_fail++; $display("FAIL w1c_after_set got %08h want 00000000", d);
        end
        irq[0] = 1'b0;
        idle(5);
    endtask

    task automatic test_reset_mid_claim();
        logic [31:0] d;
        irq[0] = 1'b1;
        idle(5);
        irq[0] = 1'b0;
        idle(5);
        n_checks++;
        if (hwint !== 1'b1) begin
            n_fail++; $display("FAIL rstclaim_setup_hwint got %0b want 1", hwint);
        end
        cs = 1'b1; rd = 1'b1; addr = 2'd3; rst = 1'b1;
        tick();
        cs = 1'b0; rd = 1'b0; addr = '0; rst = 1'b0;
        n_checks++;
        if (hwint !== 1'b0) begin
            n_fail++; $display("FAIL rstclaim_hwint got %0b want 0", hwint);
        end
        for (int r = 0; r < 4; r++) begin
            bus_read(2'(r), d);
            n_checks++;
            if (d !== 32'h0) begin
                n_fail++; $display("FAIL rstclaim_reg%0d got %08h want 00000000", r, d);
            end
        end
        n_checks++;
        if (hwint !== 1'b0) begin
            n_fail++; $display("FAIL rstclaim_hwint_stays got %0b want 0", hwint);
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst = 1'b1; irq = '0; cs = 1'b0; rd = 1'b0; wr = 1'b0; addr = '0; wdata = '0;
        idle(2);
        test_reset();
        test_bus_rules();
        test_edge_latency();
        test_w1c_edge_hold();
        test_level_claim();
        test_priority();
        test_set_wins();
        test_reset_mid_claim();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
